// File: rtl/antirrebotes_pkg.sv
// -----------------------------------------------------------------------------
// antirrebotes_pkg
// Shared types and default constants for the multichannel debouncer.
//   estado_t         : per-channel debounce FSM state (2 bits)
//   SYNC_STAGES_DEF  : default synchroniser depth
//   STABLE_TICKS_DEF : default number of ticks a new level must persist
// Optional feature macro used by this design: ANTIRREBOTES_EDGE_EN.
// -----------------------------------------------------------------------------
package antirrebotes_pkg;

    typedef enum logic [1:0] {
        ESTABLE_BAJO = 2'd0,
        VERIF_ALTO   = 2'd1,
        ESTABLE_ALTO = 2'd2,
        VERIF_BAJO   = 2'd3
    } estado_t;

    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned STABLE_TICKS_DEF = 50000;

endpackage

// File: rtl/antirrebotes_multicanal_if.sv
// -----------------------------------------------------------------------------
// antirrebotes_multicanal_if
// Groups the debouncer data signals.
//   tick         : sample strobe (counters advance only when 1)
//   dato_entrada : raw asynchronous inputs, one bit per channel
//   dato_salida  : debounced levels
//   pulso_subida : one-cycle pulse on each accepted 0->1 change
//   pulso_bajada : one-cycle pulse on each accepted 1->0 change
// Modports: master (stimulus side), slave (debouncer side).
// -----------------------------------------------------------------------------
interface antirrebotes_multicanal_if #(
    parameter int unsigned N_CH = 4
);
    logic            tick;
    logic [N_CH-1:0] dato_entrada;
    logic [N_CH-1:0] dato_salida;
    logic [N_CH-1:0] pulso_subida;
    logic [N_CH-1:0] pulso_bajada;

    modport master (
        output tick,
        output dato_entrada,
        input  dato_salida,
        input  pulso_subida,
        input  pulso_bajada
    );

    modport slave (
        input  tick,
        input  dato_entrada,
        output dato_salida,
        output pulso_subida,
        output pulso_bajada
    );
endinterface

// File: rtl/antirrebotes_canal.sv
// -----------------------------------------------------------------------------
// antirrebotes_canal
// One debounce channel: synchroniser chain, 4-state FSM with stable-time
// counter, and (when ANTIRREBOTES_EDGE_EN is defined) registered edge pulses.
// Ports:
//   clk, reset (sync, active-high)
//   tick          : counter advance strobe
//   dato_entrada  : raw asynchronous input
//   dato_salida   : debounced level (registered)
//   pulso_subida  : one-cycle pulse when dato_salida goes 0->1
//   pulso_bajada  : one-cycle pulse when dato_salida goes 1->0
// Without ANTIRREBOTES_EDGE_EN the pulse outputs are tied to 0.
// -----------------------------------------------------------------------------
module antirrebotes_canal
    import antirrebotes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int unsigned CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic dato_entrada,
    output logic dato_salida,
    output logic pulso_subida,
    output logic pulso_bajada
);

    localparam logic [CNT_W-1:0] CntUlt = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CntUno = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    estado_t                estado_q, estado_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   salida_q, salida_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], dato_entrada};
    assign s      = sync_q[SYNC_STAGES-1];

    // cnt holds the number of tick edges already seen with s differing from
    // the accepted level. The edge that leaves a stable state counts as the
    // first one when tick is high, so acceptance lands on the STABLE_TICKS-th
    // qualifying edge after s changes.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
        unique case (estado_q)
            ESTABLE_BAJO: begin
                cnt_d = '0;
                if (s) begin
                    if (tick && (CntUlt == '0)) begin
                        estado_d = ESTABLE_ALTO;
                        salida_d = 1'b1;
                    end else begin
                        estado_d = VERIF_ALTO;
                        cnt_d    = tick ? CntUno : '0;
                    end
                end
            end
            VERIF_ALTO: begin
                // Glitch reject wins over the tick on the same edge.
                if (!s) begin
                    estado_d = ESTABLE_BAJO;
                    cnt_d    = '0;
                end else if (tick) begin
                    if (cnt_q == CntUlt) begin
                        estado_d = ESTABLE_ALTO;
                        salida_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CntUno;
                    end
                end
            end
            ESTABLE_ALTO: begin
                cnt_d = '0;
                if (!s) begin
                    if (tick && (CntUlt == '0)) begin
                        estado_d = ESTABLE_BAJO;
                        salida_d = 1'b0;
                    end else begin
                        estado_d = VERIF_BAJO;
                        cnt_d    = tick ? CntUno : '0;
                    end
                end
            end
            VERIF_BAJO: begin
                if (s) begin
                    estado_d = ESTABLE_ALTO;
                    cnt_d    = '0;
                end else if (tick) begin
                    if (cnt_q == CntUlt) begin
                        estado_d = ESTABLE_BAJO;
                        salida_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CntUno;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            estado_q <= ESTABLE_BAJO;
            cnt_q    <= '0;
            salida_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
        end
    end

    assign dato_salida = salida_q;

`ifdef ANTIRREBOTES_EDGE_EN
    logic subida_q, subida_d;
    logic bajada_q, bajada_d;

    // Pulses are registered alongside salida_q so they line up with the level change.
    always_comb begin
        subida_d = salida_d & ~salida_q;
        bajada_d = ~salida_d & salida_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            subida_q <= 1'b0;
            bajada_q <= 1'b0;
        end else begin
            subida_q <= subida_d;
            bajada_q <= bajada_d;
        end
    end

    assign pulso_subida = subida_q;
    assign pulso_bajada = bajada_q;
`else
    assign pulso_subida = 1'b0;
    assign pulso_bajada = 1'b0;
`endif

endmodule

// File: rtl/antirrebotes_multicanal.sv
// -----------------------------------------------------------------------------
// antirrebotes_multicanal
// N_CH independent debounce channels, one antirrebotes_canal each.
// Ports:
//   clk, reset (sync, active-high)
//   bus (slave modport): tick, dato_entrada in; dato_salida, pulso_subida,
//                        pulso_bajada out (all N_CH wide except tick)
// Edge pulses are built only when ANTIRREBOTES_EDGE_EN is defined; otherwise
// the pulse buses read constant 0.
// -----------------------------------------------------------------------------
module antirrebotes_multicanal
    import antirrebotes_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int unsigned CNT_W        = $clog2(STABLE_TICKS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    antirrebotes_multicanal_if.slave  bus
);

    logic [N_CH-1:0] salida;
    logic [N_CH-1:0] subida;
    logic [N_CH-1:0] bajada;

    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        antirrebotes_canal #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_canal (
            .clk          (clk),
            .reset        (reset),
            .tick         (bus.tick),
            .dato_entrada (bus.dato_entrada[i]),
            .dato_salida  (salida[i]),
            .pulso_subida (subida[i]),
            .pulso_bajada (bajada[i])
        );
    end

    assign bus.dato_salida  = salida;
    assign bus.pulso_subida = subida;
    assign bus.pulso_bajada = bajada;

endmodule

// File: doc/antirrebotes_multicanal.md
# antirrebotes_multicanal

Parametrised N-channel debouncer. Each channel has a configurable synchroniser depth and a stable-time threshold counted in qualifying `tick` strobes. It produces a clean level per channel plus optional one-cycle rising/falling edge pulses. It sits between raw push-button/switch pins and the control FSMs, and replaces per-signal fixed flip-flop-chain debouncing.

## Interface
Parameters:
- `N_CH`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `STABLE_TICKS`, default 50000: consecutive ticks a changed level must persist before it is accepted (≥1).
- `CNT_W`, default `$clog2(STABLE_TICKS+1)`: counter width, derived; not overridden.

Ports:
- `clk`, in, 1: single clock. All logic runs on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: sample strobe; counters advance only when it is 1. Tie it to 1 for clk-rate counting.
- `dato_entrada`, in, N_CH: raw asynchronous inputs.
- `dato_salida`, out, N_CH: debounced levels.
- `pulso_subida`, out, N_CH: one-cycle pulse when `dato_salida[i]` goes 0→1.
- `pulso_bajada`, out, N_CH: one-cycle pulse when `dato_salida[i]` goes 1→0.

## Operation
- Each channel is independent; there is no cross-channel interaction.
- Synchroniser: `dato_entrada[i]` passes through a `SYNC_STAGES`-deep flop chain. The last stage is `s[i]`.
- Per-channel FSM, 2-bit state:
  - ESTABLE_BAJO: `dato_salida`=0, cnt=0. If `s`=1, go to VERIF_ALTO.
  - VERIF_ALTO: on each edge with `s`=0, go to ESTABLE_BAJO and set cnt=0. This happens on any clk edge, independent of `tick`. Else, if `tick`=1: when cnt==STABLE_TICKS-1, go to ESTABLE_ALTO, set `dato_salida`=1 and cnt=0, and pulse `pulso_subida`; otherwise cnt++.
  - ESTABLE_ALTO / VERIF_BAJO: mirror image with 0/1 swapped; acceptance pulses `pulso_bajada`.
- The glitch-reject clear has priority over the tick increment on the same edge.
- The counter never exceeds STABLE_TICKS-1; there is no wrap-around.
- STABLE_TICKS=1: a change is accepted on the first tick edge after `s` differs.
- Pulses are registered. They assert in the same cycle `dato_salida` changes and last exactly one clk cycle, regardless of `tick`.

## Timing
- Reset values: all sync flops 0, `dato_salida`=0, `pulso_subida`=0, `pulso_bajada`=0, every FSM in ESTABLE_BAJO, cnt=0.
- Reset mid-count discards the count. The first post-reset edge without `reset` starts from the reset state.
- Latency with `tick`≡1 and the input stable after a change sampled at edge 1: `dato_salida` updates at edge SYNC_STAGES+STABLE_TICKS.
- With sparse `tick`, only tick edges increment cnt. Non-tick edges hold cnt, unless the input reverts.
- A `reset` asserted on the same edge as an acceptance wins: outputs return to 0 and no pulse is issued.

## Configuration
- `ANTIRREBOTES_EDGE_EN` defined: edge-pulse registers and logic are built as described.
- Not defined: `pulso_subida` and `pulso_bajada` are driven constant 0, no pulse flops are synthesised, and the ports remain present.

## Structure
- Package `antirrebotes_pkg`:
  - state typedef `estado_t` {ESTABLE_BAJO, VERIF_ALTO, ESTABLE_ALTO, VERIF_BAJO};
  - default constants for SYNC_STAGES and STABLE_TICKS.
- Sub-module `antirrebotes_canal`: one channel (synchroniser, FSM, counter, edge pulses). The top is a generate loop of N_CH instances.

## Test plan
Bench parameters: N_CH=4, SYNC_STAGES=2, STABLE_TICKS=4, `tick`≡1 unless stated.
- Reset: `reset`=1 for 3 cycles with inputs at 4'hF → all outputs 0 throughout reset. After release, ch0–3 go high at edge 6 with a single `pulso_subida`=4'hF cycle.
- Clean press: ch0 0→1 held → `dato_salida[0]`=1 at edge 6 after the change, `pulso_subida[0]` high for exactly that cycle. Other channels unchanged.
- Glitch: ch1 high for 3 cycles then low → `dato_salida[1]` stays 0 and no pulses.
- Bounce: ch2 toggles 1,0,1,0,1 then held 1 → acceptance occurs 6 edges after the final rising change, with one pulse only.
- Sparse tick: `tick` every 3rd cycle, ch3 held 1 → output rises on the 4th tick edge after the sync output changes, and cnt holds between ticks.
- Reset mid-count: ch0 held 1 and `reset` pulsed at count 2 → output stays 0, and acceptance restarts from 0 after release.
- Macro off: repeat the clean press → level behaviour identical, and both pulse buses remain 0.
